// File: rtl/ahb2apb_pkg.sv
// Shared types for the multi-completer AHB-to-APB bridge: FSM states, HTRANS
// encodings and the APB4 byte-lane strobe helper.
package ahb2apb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PEND   = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_ERR1   = 3'd4,
    ST_ERR2   = 3'd5
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // Byte lanes covered by an access of 2**size bytes at addr_lsbs, for a bus of dw bits.
  function automatic logic [7:0] strb(input logic [2:0] size, input logic [2:0] addr_lsbs,
                                      input int dw);
    int lanes;
    int nbytes;
    int base;
    logic [7:0] mask;
    lanes  = dw / 8;
    nbytes = 1 << int'(size);
    base   = ((int'(addr_lsbs) % lanes) / nbytes) * nbytes;
    mask   = 8'h00;
    for (int i = 0; i < 8; i++) begin
      mask[i] = (i >= base) && (i < base + nbytes) && (i < lanes);
    end
    return mask;
  endfunction

endpackage

// File: rtl/ahb2apb_slv_dec.sv
// Completer decode: picks the index field out of the address, produces the one-hot
// select and flags out-of-range indices or transfer sizes wider than the bus.
module ahb2apb_slv_dec
  import ahb2apb_pkg::*;
#(
  parameter int ADDRWIDTH    = 16,
  parameter int DATAWIDTH    = 32,
  parameter int NUM_SLAVES   = 4,
  parameter int SLV_ADDR_LSB = 12
) (
  input  logic [ADDRWIDTH-1:0]  i_addr,
  input  logic [2:0]            i_size,
  output logic [NUM_SLAVES-1:0] o_sel,
  output logic                  o_err
);

  localparam int         IDXW     = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [2:0] MAX_SIZE = 3'($clog2(DATAWIDTH / 8));

  logic [IDXW-1:0] w_idx;
  logic            w_unused;

  // A single completer has a zero-width index field, so its index is always 0.
  generate
    if (NUM_SLAVES > 1) begin : g_idx
      assign w_idx = i_addr[SLV_ADDR_LSB +: IDXW];
    end else begin : g_one
      assign w_idx = 1'b0;
    end
  endgenerate

  assign w_unused = ^i_addr;

  always_comb begin
    o_sel = '0;
    o_err = 1'b0;
    if ((int'(w_idx) >= NUM_SLAVES) || (i_size > MAX_SIZE)) begin
      o_err = 1'b1;
    end else begin
      o_sel[w_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/ahb2apb_bridge_mslv.sv
// AHB-to-APB bridge for up to 16 completers with PREADY/PSLVERR and a PCLKEN-divided
// APB clock. Define AHB2APB_APB4_EN to add the APB4 PPROT and PSTRB outputs.
module ahb2apb_bridge_mslv
  import ahb2apb_pkg::*;
#(
  parameter int ADDRWIDTH    = 16,
  parameter int DATAWIDTH    = 32,
  parameter int NUM_SLAVES   = 4,
  parameter int SLV_ADDR_LSB = 12
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic                   HSEL,
  input  logic                   HREADY,
  input  logic                   HWRITE,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HSIZE,
  input  logic [3:0]             HPROT,
  input  logic [ADDRWIDTH-1:0]   HADDR,
  input  logic [DATAWIDTH-1:0]   HWDATA,
  output logic                   HREADYOUT,
  output logic                   HRESP,
  output logic [DATAWIDTH-1:0]   HRDATA,
  input  logic                   PCLKEN,
  input  logic                   PREADY,
  input  logic                   PSLVERR,
  input  logic [DATAWIDTH-1:0]   PRDATA,
  output logic [NUM_SLAVES-1:0]  PSEL,
  output logic                   PENABLE,
  output logic                   PWRITE,
  output logic [ADDRWIDTH-1:0]   PADDR,
  output logic [DATAWIDTH-1:0]   PWDATA,
`ifdef AHB2APB_APB4_EN
  output logic [2:0]             PPROT,
  output logic [DATAWIDTH/8-1:0] PSTRB,
`endif
  output logic                   APBACTIVE
);

  localparam int                   ALIGN    = $clog2(DATAWIDTH / 8);
  localparam logic [ADDRWIDTH-1:0] LOW_MASK = ADDRWIDTH'((1 << ALIGN) - 1);

  state_t                  r_state;
  logic [NUM_SLAVES-1:0]   r_sel;
  logic [NUM_SLAVES-1:0]   r_psel;
  logic                    r_hreadyout;
  logic                    r_hresp;
  logic                    r_penable;
  logic                    r_pwrite;
  logic [ADDRWIDTH-1:0]    r_paddr;
  logic [DATAWIDTH-1:0]    r_pwdata;
  logic [DATAWIDTH-1:0]    r_hrdata;
  logic                    r_apbactive;

  logic                    w_accept;
  logic                    w_dec_err;
  logic [NUM_SLAVES-1:0]   w_sel;
  logic                    w_unused;

  ahb2apb_slv_dec #(
    .ADDRWIDTH    (ADDRWIDTH),
    .DATAWIDTH    (DATAWIDTH),
    .NUM_SLAVES   (NUM_SLAVES),
    .SLV_ADDR_LSB (SLV_ADDR_LSB)
  ) u_dec (
    .i_addr (HADDR),
    .i_size (HSIZE),
    .o_sel  (w_sel),
    .o_err  (w_dec_err)
  );

  // ERR2 already drives HREADYOUT high, so a pipelined transfer may start there.
  assign w_accept = HSEL & HREADY & HTRANS[1] &
                    ((r_state == ST_IDLE) | (r_state == ST_ERR2));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state     <= ST_IDLE;
      r_sel       <= '0;
      r_psel      <= '0;
      r_hreadyout <= 1'b1;
      r_hresp     <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_hrdata    <= '0;
      r_apbactive <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_ERR2: begin
          if (w_accept) begin
            r_paddr     <= HADDR & ~LOW_MASK;
            r_pwrite    <= HWRITE;
            r_sel       <= w_sel;
            r_hreadyout <= 1'b0;
            r_apbactive <= 1'b1;
            if (w_dec_err) begin
              r_state <= ST_ERR1;
              r_hresp <= 1'b1;
            end else begin
              r_state <= ST_PEND;
              r_hresp <= 1'b0;
            end
          end else begin
            r_state     <= ST_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
            r_apbactive <= 1'b0;
          end
        end
        ST_PEND: begin
          if (PCLKEN) begin
            r_state  <= ST_SETUP;
            r_pwdata <= HWDATA;
            r_psel   <= r_sel;
          end
        end
        ST_SETUP: begin
          if (PCLKEN) begin
            r_state   <= ST_ACCESS;
            r_penable <= 1'b1;
          end
        end
        ST_ACCESS: begin
          if (PCLKEN && PREADY) begin
            r_penable <= 1'b0;
            r_psel    <= '0;
            if (!r_pwrite) begin
              r_hrdata <= PRDATA;
            end
            if (PSLVERR) begin
              r_state <= ST_ERR1;
              r_hresp <= 1'b1;
            end else begin
              r_state     <= ST_IDLE;
              r_hreadyout <= 1'b1;
              r_apbactive <= 1'b0;
            end
          end
        end
        ST_ERR1: begin
          r_state     <= ST_ERR2;
          r_hreadyout <= 1'b1;
          r_hresp     <= 1'b1;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_psel      <= '0;
          r_penable   <= 1'b0;
          r_hreadyout <= 1'b1;
          r_hresp     <= 1'b0;
          r_apbactive <= 1'b0;
        end
      endcase
    end
  end

  assign HREADYOUT = r_hreadyout;
  assign HRESP     = r_hresp;
  assign HRDATA    = r_hrdata;
  assign PSEL      = r_psel;
  assign PENABLE   = r_penable;
  assign PWRITE    = r_pwrite;
  assign PADDR     = r_paddr;
  assign PWDATA    = r_pwdata;
  assign APBACTIVE = r_apbactive;

`ifdef AHB2APB_APB4_EN
  logic [2:0]             r_pprot;
  logic [DATAWIDTH/8-1:0] r_pstrb;
  logic [7:0]             w_strb_full;

  assign w_strb_full = strb(HSIZE, HADDR[2:0], DATAWIDTH);

  // APB4 attributes are captured alongside the address; reads drive no strobes.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_pprot <= 3'b000;
      r_pstrb <= '0;
    end else if (w_accept) begin
      r_pprot <= {~HPROT[0], 1'b0, HPROT[1]};
      r_pstrb <= HWRITE ? w_strb_full[DATAWIDTH/8-1:0] : '0;
    end
  end

  assign PPROT    = r_pprot;
  assign PSTRB    = r_pstrb;
  assign w_unused = ^{HTRANS[0], HPROT, w_strb_full};
`else
  assign w_unused = ^{HTRANS[0], HPROT};
`endif

endmodule

// File: tb/tb_ahb2apb_bridge_mslv.sv
// Directed bench for ahb2apb_bridge_mslv: a 4-completer and a 3-completer bridge
// share one AHB/APB stimulus; APB4 checks run when AHB2APB_APB4_EN is defined.
module tb_ahb2apb_bridge_mslv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hsel0, hsel1, hready, hwrite;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [3:0]  hprot;
  logic [15:0] haddr;
  logic [31:0] hwdata;
  logic        pclken, pready, pslverr;
  logic [31:0] prdata;

  logic        hro0, hresp0, pen0, pwr0, act0;
  logic [31:0] hrdata0, pwdata0;
  logic [3:0]  psel0;
  logic [15:0] paddr0;
  logic        hro1, hresp1, pen1, pwr1, act1;
  logic [31:0] hrdata1, pwdata1;
  logic [2:0]  psel1;
  logic [15:0] paddr1;
`ifdef AHB2APB_APB4_EN
  logic [2:0]  pprot0, pprot1;
  logic [3:0]  pstrb0, pstrb1;
`endif

  always #5 clk = ~clk;

  ahb2apb_bridge_mslv #(.ADDRWIDTH(16), .DATAWIDTH(32), .NUM_SLAVES(4), .SLV_ADDR_LSB(12)) u_dut4 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel0), .HREADY(hready), .HWRITE(hwrite),
    .HTRANS(htrans), .HSIZE(hsize), .HPROT(hprot), .HADDR(haddr), .HWDATA(hwdata),
    .HREADYOUT(hro0), .HRESP(hresp0), .HRDATA(hrdata0), .PCLKEN(pclken), .PREADY(pready),
    .PSLVERR(pslverr), .PRDATA(prdata), .PSEL(psel0), .PENABLE(pen0), .PWRITE(pwr0),
    .PADDR(paddr0), .PWDATA(pwdata0),
`ifdef AHB2APB_APB4_EN
    .PPROT(pprot0), .PSTRB(pstrb0),
`endif
    .APBACTIVE(act0)
  );

  ahb2apb_bridge_mslv #(.ADDRWIDTH(16), .DATAWIDTH(32), .NUM_SLAVES(3), .SLV_ADDR_LSB(12)) u_dut3 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel1), .HREADY(hready), .HWRITE(hwrite),
    .HTRANS(htrans), .HSIZE(hsize), .HPROT(hprot), .HADDR(haddr), .HWDATA(hwdata),
    .HREADYOUT(hro1), .HRESP(hresp1), .HRDATA(hrdata1), .PCLKEN(pclken), .PREADY(pready),
    .PSLVERR(pslverr), .PRDATA(prdata), .PSEL(psel1), .PENABLE(pen1), .PWRITE(pwr1),
    .PADDR(paddr1), .PWDATA(pwdata1),
`ifdef AHB2APB_APB4_EN
    .PPROT(pprot1), .PSTRB(pstrb1),
`endif
    .APBACTIVE(act1)
  );

  // Observation mux: cur selects which bridge the running transfer targets.
  bit          cur;
  logic        m_hro, m_hresp, m_pen, m_pwr, m_act;
  logic [3:0]  m_psel;
  logic [15:0] m_paddr;
  logic [31:0] m_pwdata;
  assign m_hro    = cur ? hro1 : hro0;
  assign m_hresp  = cur ? hresp1 : hresp0;
  assign m_pen    = cur ? pen1 : pen0;
  assign m_pwr    = cur ? pwr1 : pwr0;
  assign m_act    = cur ? act1 : act0;
  assign m_psel   = cur ? {1'b0, psel1} : psel0;
  assign m_paddr  = cur ? paddr1 : paddr0;
  assign m_pwdata = cur ? pwdata1 : pwdata0;
`ifdef AHB2APB_APB4_EN
  logic [2:0] m_pprot;
  logic [3:0] m_pstrb;
  assign m_pprot = cur ? pprot1 : pprot0;
  assign m_pstrb = cur ? pstrb1 : pstrb0;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int cyc;

  int          obs_waits, obs_err1, obs_err2;
  logic [3:0]  obs_psel, obs_psel_any;
  logic [15:0] obs_paddr;
  logic [31:0] obs_pwdata;
  logic        obs_pwrite;
  bit          obs_unstable, obs_bad_pen, obs_active;
  logic [2:0]  obs_pprot;
  logic [3:0]  obs_pstrb;

  // Drive an address phase (called at a negedge; the following posedge accepts it).
  task automatic start_addr(input bit which, input logic [15:0] a, input logic wr,
                            input logic [2:0] sz);
    cur    = which;
    hsel0  = !which;
    hsel1  = which;
    htrans = 2'b10;
    haddr  = a;
    hwrite = wr;
    hsize  = sz;
    hready = 1'b1;
    cyc    = 0;
    pclken = 1'b1;
    pready = 1'b1;
  endtask

  // Data phase: runs from the negedge after accept until HREADYOUT=1/HRESP=0.
  task automatic run_data(input logic [31:0] wd, input int stalls, input int div,
                          input logic slverr);
    int          left;
    logic        prev_pen, prev_clken;
    bit          done, have_first;
    logic [15:0] first_paddr;
    left = stalls; prev_pen = m_pen; prev_clken = pclken; done = 0; have_first = 0;
    first_paddr = 16'h0000;
    hsel0 = 1'b0; hsel1 = 1'b0; htrans = 2'b00; hwdata = wd; pslverr = slverr;
    obs_waits = 0; obs_err1 = 0; obs_err2 = 0; obs_psel = 4'h0; obs_psel_any = 4'h0;
    obs_paddr = 16'h0; obs_pwdata = 32'h0; obs_pwrite = 1'bx;
    obs_unstable = 0; obs_bad_pen = 0; obs_active = 0;
    obs_pprot = 3'bxxx; obs_pstrb = 4'hx;
    for (int i = 0; i < 200 && !done; i++) begin
      if (m_pen !== prev_pen && !prev_clken) obs_bad_pen = 1;
      prev_pen = m_pen;
      if (m_psel !== 4'h0) begin
        obs_psel_any = obs_psel_any | m_psel;
        if (!have_first) begin
          first_paddr = m_paddr; obs_psel = m_psel; have_first = 1;
        end else if (m_paddr !== first_paddr || m_psel !== obs_psel) begin
          obs_unstable = 1;
        end
      end
      if (m_pen === 1'b1) begin
        obs_paddr = m_paddr; obs_pwdata = m_pwdata; obs_pwrite = m_pwr;
`ifdef AHB2APB_APB4_EN
        obs_pprot = m_pprot; obs_pstrb = m_pstrb;
`endif
      end
      if (m_act === 1'b1) obs_active = 1;
      if (m_hro === 1'b0 && m_hresp === 1'b0) obs_waits++;
      else if (m_hro === 1'b0 && m_hresp === 1'b1) obs_err1++;
      else if (m_hro === 1'b1 && m_hresp === 1'b1) obs_err2++;
      else done = 1;
      if (!done) begin
        cyc++;
        pclken = (cyc % div == 0);
        pready = (left == 0);
        if (m_pen === 1'b1 && pclken && left > 0) left--;
        prev_clken = pclken;
        @(negedge clk);
      end
    end
    n_checks++;
    if (!done) $display("FAIL xfer_timeout: HREADYOUT=%b HRESP=%b, required completion", m_hro, m_hresp);
    else n_pass++;
    pslverr = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    n_checks++;
    if ({hro0, hresp0, psel0, pen0, pwr0, act0} !== 9'b1_0_0000_0_0_0)
      $display("FAIL reset_ctl: got %b required 100000000", {hro0, hresp0, psel0, pen0, pwr0, act0});
    else n_pass++;
    n_checks++;
    if (paddr0 !== 16'h0 || pwdata0 !== 32'h0) $display("FAIL reset_apb: paddr=%h pwdata=%h required 0", paddr0, pwdata0);
    else n_pass++;
    n_checks++;
    if (hrdata0 !== 32'h0 || hrdata1 !== 32'h0) $display("FAIL reset_hrdata: %h/%h required 0", hrdata0, hrdata1);
    else n_pass++;
    n_checks++;
    if ({hro1, hresp1, psel1, act1} !== 6'b10_000_0) $display("FAIL reset_dut3: got %b", {hro1, hresp1, psel1, act1});
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write();
    start_addr(1'b0, 16'h2004, 1'b1, 3'd2);
    @(negedge clk);
    run_data(32'hA5A5_0001, 0, 1, 1'b0);
    n_checks++;
    if (obs_waits != 3) $display("FAIL wr_waits: got %0d required 3", obs_waits); else n_pass++;
    n_checks++;
    if (obs_err1 + obs_err2 != 0) $display("FAIL wr_hresp: error cycles %0d required 0", obs_err1 + obs_err2); else n_pass++;
    n_checks++;
    if (obs_psel !== 4'b0100) $display("FAIL wr_psel: got %b required 0100", obs_psel); else n_pass++;
    n_checks++;
    if (obs_paddr !== 16'h2004 || obs_pwrite !== 1'b1) $display("FAIL wr_paddr: got %h/%b required 2004/1", obs_paddr, obs_pwrite); else n_pass++;
    n_checks++;
    if (obs_pwdata !== 32'hA5A5_0001) $display("FAIL wr_pwdata: got %h required a5a50001", obs_pwdata); else n_pass++;
    n_checks++;
    if (!obs_active || act0 !== 1'b0 || hrdata0 !== 32'h0)
      $display("FAIL wr_active_hrdata: seen=%0d now=%b hrdata=%h required 1/0/0", obs_active, act0, hrdata0);
    else n_pass++;
  endtask

  task automatic test_read_waits();
    prdata = 32'h1234_5678;
    start_addr(1'b0, 16'h1006, 1'b0, 3'd1);
    @(negedge clk);
    run_data(32'hFFFF_FFFF, 2, 1, 1'b0);
    n_checks++;
    if (obs_waits != 5) $display("FAIL rd_waits: got %0d required 5", obs_waits); else n_pass++;
    n_checks++;
    if (hrdata0 !== 32'h1234_5678) $display("FAIL rd_hrdata: got %h required 12345678", hrdata0); else n_pass++;
    n_checks++;
    if (obs_psel !== 4'b0010 || obs_paddr !== 16'h1004 || obs_pwrite !== 1'b0)
      $display("FAIL rd_apb: psel=%b paddr=%h pwrite=%b required 0010/1004/0", obs_psel, obs_paddr, obs_pwrite);
    else n_pass++;
  endtask

  task automatic test_pclken_div();
    prdata = 32'h0;
    start_addr(1'b0, 16'h3FFC, 1'b1, 3'd2);
    @(negedge clk);
    run_data(32'h0BAD_F00D, 0, 3, 1'b0);
    n_checks++;
    if (obs_waits != 9) $display("FAIL div_waits: got %0d required 9", obs_waits); else n_pass++;
    n_checks++;
    if (obs_bad_pen) $display("FAIL div_penable: edge without PCLKEN got 1 required 0"); else n_pass++;
    n_checks++;
    if (obs_unstable || obs_paddr !== 16'h3FFC || obs_psel !== 4'b1000)
      $display("FAIL div_stable: unstable=%0d paddr=%h psel=%b required 0/3ffc/1000", obs_unstable, obs_paddr, obs_psel);
    else n_pass++;
    n_checks++;
    if (hrdata0 !== 32'h1234_5678) $display("FAIL div_hrdata_hold: got %h required 12345678", hrdata0); else n_pass++;
  endtask

  task automatic test_slverr();
    prdata = 32'hDEAD_BEEF;
    start_addr(1'b0, 16'h0010, 1'b0, 3'd2);
    @(negedge clk);
    run_data(32'h0, 0, 1, 1'b1);
    n_checks++;
    if (obs_waits != 3 || obs_err1 != 1 || obs_err2 != 1)
      $display("FAIL slverr_resp: waits=%0d err1=%0d err2=%0d required 3/1/1", obs_waits, obs_err1, obs_err2);
    else n_pass++;
    n_checks++;
    if (act0 !== 1'b0 || hro0 !== 1'b1) $display("FAIL slverr_idle: act=%b hro=%b required 0/1", act0, hro0); else n_pass++;
  endtask

  task automatic test_decode_err_back_to_back();
    start_addr(1'b1, 16'h3000, 1'b1, 3'd2);
    @(negedge clk);
    hsel1 = 1'b0; htrans = 2'b00;
    n_checks++;
    if ({hro1, hresp1, psel1} !== 5'b0_1_000) $display("FAIL dec_err1: got %b required 01000", {hro1, hresp1, psel1}); else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({hro1, hresp1, psel1} !== 5'b1_1_000) $display("FAIL dec_err2: got %b required 11000", {hro1, hresp1, psel1}); else n_pass++;
    start_addr(1'b1, 16'h1008, 1'b1, 3'd2);
    @(negedge clk);
    run_data(32'h0000_C0DE, 0, 1, 1'b0);
    n_checks++;
    if (obs_waits != 3 || obs_err1 + obs_err2 != 0) $display("FAIL b2b_resp: waits=%0d err=%0d required 3/0", obs_waits, obs_err1 + obs_err2); else n_pass++;
    n_checks++;
    if (obs_psel !== 4'b0010 || obs_paddr !== 16'h1008 || obs_pwdata !== 32'h0000_C0DE)
      $display("FAIL b2b_apb: psel=%b paddr=%h pwdata=%h required 0010/1008/0000c0de", obs_psel, obs_paddr, obs_pwdata);
    else n_pass++;
    start_addr(1'b0, 16'h0000, 1'b0, 3'd3);
    @(negedge clk);
    run_data(32'h0, 0, 1, 1'b0);
    n_checks++;
    if (obs_waits != 0 || obs_err1 != 1 || obs_err2 != 1 || obs_psel_any !== 4'h0)
      $display("FAIL size_err: waits=%0d err1=%0d err2=%0d psel=%b required 0/1/1/0000", obs_waits, obs_err1, obs_err2, obs_psel_any);
    else n_pass++;
  endtask

`ifdef AHB2APB_APB4_EN
  task automatic test_apb4();
    hprot = 4'b0011;
    start_addr(1'b0, 16'h0002, 1'b1, 3'd0);
    @(negedge clk);
    run_data(32'h00AB_0000, 0, 1, 1'b0);
    n_checks++;
    if (obs_pstrb !== 4'b0100) $display("FAIL apb4_wr_strb: got %b required 0100", obs_pstrb); else n_pass++;
    n_checks++;
    if (obs_pprot !== 3'b001) $display("FAIL apb4_pprot: got %b required 001", obs_pprot); else n_pass++;
    start_addr(1'b0, 16'h0002, 1'b0, 3'd0);
    @(negedge clk);
    run_data(32'h0, 0, 1, 1'b0);
    n_checks++;
    if (obs_pstrb !== 4'b0000) $display("FAIL apb4_rd_strb: got %b required 0000", obs_pstrb); else n_pass++;
    hprot = 4'b0000;
  endtask
`endif

  task automatic test_mid_reset();
    start_addr(1'b0, 16'h2000, 1'b1, 3'd2);
    @(negedge clk);
    hsel0 = 1'b0; htrans = 2'b00; hwdata = 32'h7777_0000;
    @(negedge clk);
    n_checks++;
    if (psel0 !== 4'b0100 || act0 !== 1'b1) $display("FAIL mid_setup: psel=%b act=%b required 0100/1", psel0, act0); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({hro0, hresp0, psel0, pen0, pwr0, act0} !== 9'b1_0_0000_0_0_0)
      $display("FAIL mid_reset_ctl: got %b required 100000000", {hro0, hresp0, psel0, pen0, pwr0, act0});
    else n_pass++;
    n_checks++;
    if (paddr0 !== 16'h0 || pwdata0 !== 32'h0 || hrdata0 !== 32'h0)
      $display("FAIL mid_reset_data: paddr=%h pwdata=%h hrdata=%h required 0", paddr0, pwdata0, hrdata0);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); @(negedge clk);
    n_checks++;
    if (hro0 !== 1'b1 || act0 !== 1'b0 || psel0 !== 4'h0) $display("FAIL post_reset_idle: hro=%b act=%b psel=%b", hro0, act0, psel0); else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0; cur = 1'b0;
    hsel0 = 1'b0; hsel1 = 1'b0; hready = 1'b1; hwrite = 1'b0; htrans = 2'b00;
    hsize = 3'd0; hprot = 4'b0000; haddr = 16'h0; hwdata = 32'h0;
    pclken = 1'b1; pready = 1'b1; pslverr = 1'b0; prdata = 32'h0; cyc = 0;
    test_reset();
    test_write();
    test_read_waits();
    test_pclken_div();
    test_slverr();
    test_decode_err_back_to_back();
`ifdef AHB2APB_APB4_EN
    test_apb4();
`endif
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
